// File: rtl/mux_arb_pkg.sv
// Shared types and constants for the eight-way round-robin mux arbiter.
package mux_arb_pkg;

    localparam int NUM_REQ = 8;
    localparam int SEL_W   = 3;

    typedef enum logic {
        ARB_IDLE,
        ARB_GRANT
    } arb_state_t;

    // One-hot encode a requester index into a grant vector.
    function automatic logic [NUM_REQ-1:0] onehot(input logic [SEL_W-1:0] idx);
        onehot      = '0;
        onehot[idx] = 1'b1;
    endfunction

endpackage

// File: rtl/mux_eight.sv
// Plain 8:1 bus multiplexer; the select is expected to come from a register.
module mux_eight
    import mux_arb_pkg::*;
#(
    parameter int BITS = 2
) (
    input  logic [NUM_REQ-1:0][BITS-1:0] data_i,
    input  logic [SEL_W-1:0]             sel_i,
    output logic [BITS-1:0]              data_o
);

    assign data_o = data_i[sel_i];

endmodule

// File: rtl/rr_pick_eight.sv
// Combinational rotate-priority picker: returns the first set request bit
// found scanning ptr, ptr+1, ... ptr+7 (mod 8).
module rr_pick_eight
    import mux_arb_pkg::*;
(
    input  logic [NUM_REQ-1:0] req_i,
    input  logic [SEL_W-1:0]   ptr_i,
    output logic               found_o,
    output logic [SEL_W-1:0]   idx_o
);

    logic [SEL_W-1:0] cand;

    // Scan from the farthest offset down so the nearest set bit to ptr wins.
    always_comb begin
        // NOTE: every output gets a default before the loop so no path leaves it unassigned (no latch).
        found_o = 1'b0;
        idx_o   = '0;
        cand    = '0;
        for (int i = NUM_REQ - 1; i >= 0; i--) begin
            cand = ptr_i + SEL_W'(i);
            if (req_i[cand]) begin
                found_o = 1'b1;
                idx_o   = cand;
            end
        end
    end

endmodule

// File: rtl/mux_eight_rr_arbiter.sv
// Round-robin arbiter sharing one 8:1 bus mux among eight requesters.
// A grant lasts for a whole burst; the granted bus is forwarded downstream
// under a valid/ready handshake. One IDLE cycle separates any two grants.
module mux_eight_rr_arbiter
    import mux_arb_pkg::*;
#(
    parameter int BITS      = 2,
    parameter int MAX_BURST = 16
) (
    input  logic                         clk_i,
    input  logic                         rst_ni,
    input  logic [NUM_REQ-1:0]           req_i,
    input  logic [NUM_REQ-1:0]           last_i,
    input  logic [NUM_REQ-1:0][BITS-1:0] data_i,
    input  logic                         ready_i,
    output logic                         valid_o,
    output logic [BITS-1:0]              data_o,
    output logic [SEL_W-1:0]             select_o,
    output logic [NUM_REQ-1:0]           grant_o,
    output logic                         busy_o
);

    localparam int                CNT_W    = $clog2(MAX_BURST + 1);
    localparam logic [CNT_W-1:0]  LAST_CNT = CNT_W'(MAX_BURST - 1);

    arb_state_t        state;
    logic [CNT_W-1:0]  beat_cnt;
    logic [SEL_W-1:0]  ptr;

    logic              pick_found;
    logic [SEL_W-1:0]  pick_idx;

    logic              sel_req;
    logic              sel_last;
    logic              beat;
    logic              burst_end;
    logic              withdraw;
    logic              release_grant;

    rr_pick_eight u_pick (
        .req_i   (req_i),
        .ptr_i   (ptr),
        .found_o (pick_found),
        .idx_o   (pick_idx)
    );

    mux_eight #(
        .BITS (BITS)
    ) u_mux (
        .data_i (data_i),
        .sel_i  (select_o),
        .data_o (data_o)
    );

    // Only the granted requester's req/last bits matter; others are ignored.
    assign sel_req  = req_i[select_o];
    assign sel_last = last_i[select_o];

    assign busy_o  = (state == ARB_GRANT);
    assign valid_o = busy_o & sel_req;
    assign beat    = valid_o & ready_i;

    // A burst ends on its last beat or when the beat budget is used up;
    // a dropped request releases at once without a beat.
    assign burst_end     = beat & (sel_last | (beat_cnt == LAST_CNT));
    assign withdraw      = busy_o & ~sel_req;
    assign release_grant = burst_end | withdraw;

    // Arbitration FSM with registered select/grant, beat counter and rotation pointer.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state    <= ARB_IDLE;
            select_o <= '0;
            grant_o  <= '0;
            beat_cnt <= '0;
            ptr      <= '0;
        end else begin
            // NOTE: non-blocking assignments so every register updates from pre-edge values.
            case (state)
                ARB_IDLE: begin
                    if (pick_found) begin
                        state    <= ARB_GRANT;
                        select_o <= pick_idx;
                        grant_o  <= onehot(pick_idx);
                        beat_cnt <= '0;
                    end
                end
                ARB_GRANT: begin
                    if (release_grant) begin
                        state    <= ARB_IDLE;
                        grant_o  <= '0;
                        beat_cnt <= '0;
                        ptr      <= select_o + SEL_W'(1);
                    end else if (beat) begin
                        beat_cnt <= beat_cnt + CNT_W'(1);
                    end
                end
                default: begin
                    state   <= ARB_IDLE;
                    grant_o <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mux_eight_rr_arbiter.sv
// Scoreboard bench: the driver steps a behavioural arbiter model and queues
// expected per-cycle status and expected beats; a monitor pops and compares.
module tb_mux_eight_rr_arbiter;

    localparam int BITS = 4;
    localparam int MAXB = 4;

    logic                  clk_i = 1'b0;
    logic                  rst_ni;
    logic [7:0]            req_i;
    logic [7:0]            last_i;
    logic [7:0][BITS-1:0]  data_i;
    logic                  ready_i;
    logic                  valid_o;
    logic [BITS-1:0]       data_o;
    logic [2:0]            select_o;
    logic [7:0]            grant_o;
    logic                  busy_o;

    mux_eight_rr_arbiter #(
        .BITS      (BITS),
        .MAX_BURST (MAXB)
    ) dut (
        .clk_i    (clk_i),
        .rst_ni   (rst_ni),
        .req_i    (req_i),
        .last_i   (last_i),
        .data_i   (data_i),
        .ready_i  (ready_i),
        .valid_o  (valid_o),
        .data_o   (data_o),
        .select_o (select_o),
        .grant_o  (grant_o),
        .busy_o   (busy_o)
    );

    always #5 clk_i = ~clk_i;

    typedef struct packed {
        logic [7:0]      grant;
        logic [2:0]      select;
        logic            busy;
        logic            valid;
        logic [BITS-1:0] data;
    } status_t;

    typedef struct packed {
        logic [2:0]      idx;
        logic [BITS-1:0] data;
    } beat_t;

    status_t status_q[$];
    beat_t   beat_q[$];

    int n_checks = 0;
    int n_errors = 0;
    bit mon_en   = 1'b0;

    // Reference model: who owns the bus, beats taken, and where the next scan starts.
    bit m_busy;
    int m_owner;
    int m_count;
    int m_ptr;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic fail_now(input string name);
        n_checks++;
        n_errors++;
        $display("FAIL %s: condition not met", name);
    endtask

    task automatic model_reset();
        m_busy  = 1'b0;
        m_owner = 0;
        m_count = 0;
        m_ptr   = 0;
    endtask

    task automatic model_release();
        m_busy  = 1'b0;
        m_ptr   = (m_owner + 1) % 8;
        m_count = 0;
    endtask

    // Advance the model across one rising edge using the inputs held during that cycle.
    task automatic model_edge();
        if (!m_busy) begin
            for (int k = 0; k < 8; k++) begin
                int r;
                r = (m_ptr + k) % 8;
                if (req_i[r]) begin
                    m_busy  = 1'b1;
                    m_owner = r;
                    m_count = 0;
                    break;
                end
            end
        end else if (!req_i[m_owner]) begin
            model_release();
        end else if (ready_i) begin
            m_count++;
            if (last_i[m_owner] || m_count == MAXB) model_release();
        end
    endtask

    // Apply one cycle of stimulus, queue the expected response, then cross the edge.
    task automatic cycle(input logic [7:0] req, input logic [7:0] last, input logic ready);
        status_t st;
        beat_t   b;
        req_i   = req;
        last_i  = last;
        ready_i = ready;
        for (int i = 0; i < 8; i++) data_i[i] = BITS'($urandom);
        st.grant  = m_busy ? 8'(1 << m_owner) : 8'h00;
        st.select = 3'(m_owner);
        st.busy   = m_busy;
        st.valid  = m_busy && req[m_owner];
        st.data   = data_i[m_owner];
        status_q.push_back(st);
        if (st.valid && ready) begin
            b.idx  = 3'(m_owner);
            b.data = data_i[m_owner];
            beat_q.push_back(b);
        end
        @(posedge clk_i);
        #1;
        model_edge();
    endtask

    task automatic drain();
        repeat (2) cycle(8'h00, 8'h00, 1'b1);
    endtask

    status_t mon_exp;
    status_t mon_act;
    beat_t   mon_beat;

    // Monitor: compare status every cycle and every handshake beat against the queues.
    always @(negedge clk_i) begin
        if (mon_en) begin
            if (status_q.size() == 0) begin
                fail_now("status_queue_underflow");
            end else begin
                mon_exp = status_q.pop_front();
                mon_act = '{grant_o, select_o, busy_o, valid_o, data_o};
                check("status", 64'(mon_act), 64'(mon_exp));
            end
            if (valid_o && ready_i) begin
                if (beat_q.size() == 0) begin
                    fail_now("unexpected_beat");
                end else begin
                    mon_beat = beat_q.pop_front();
                    check("beat_select", 64'(select_o), 64'(mon_beat.idx));
                    check("beat_data", 64'(data_o), 64'(mon_beat.data));
                end
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] rq;
        bit         reached;

        rst_ni  = 1'b0;
        req_i   = '0;
        last_i  = '0;
        ready_i = 1'b0;
        data_i  = '0;
        model_reset();

        repeat (3) @(posedge clk_i);
        #1;
        check("reset_grant", 64'(grant_o), 64'h0);
        check("reset_busy", 64'(busy_o), 64'h0);
        check("reset_valid", 64'(valid_o), 64'h0);
        check("reset_select", 64'(select_o), 64'h0);
        rst_ni = 1'b1;
        mon_en = 1'b1;

        // Single requester 0, last on the third beat.
        cycle(8'h01, 8'h00, 1'b1);
        cycle(8'h01, 8'h00, 1'b1);
        cycle(8'h01, 8'h00, 1'b1);
        cycle(8'h01, 8'h01, 1'b1);
        cycle(8'h00, 8'h00, 1'b1);

        // Everyone requesting, single-beat bursts: rotation from requester 1.
        repeat (20) cycle(8'hFF, 8'hFF, 1'b1);
        drain();

        // Burst limit: requester 5 alone, never signals last.
        repeat (12) cycle(8'h20, 8'h00, 1'b1);
        drain();

        // Stall: requester 2 granted, ready low for five cycles.
        cycle(8'h04, 8'h00, 1'b0);
        repeat (5) cycle(8'h04, 8'h00, 1'b0);
        cycle(8'h04, 8'h00, 1'b1);
        cycle(8'h04, 8'h04, 1'b1);
        drain();

        // Withdrawal: requester 3 drops before any beat; next scan starts at 4.
        cycle(8'h08, 8'h00, 1'b0);
        cycle(8'h00, 8'h00, 1'b0);
        cycle(8'hFF, 8'hFF, 1'b1);
        check("withdraw_next_owner", 64'(grant_o), 64'h10);
        drain();

        // Randomised traffic with sticky requests.
        rq = 8'($urandom);
        repeat (1500) begin
            for (int i = 0; i < 8; i++)
                if ($urandom_range(0, 9) == 0) rq[i] = ~rq[i];
            cycle(rq, 8'($urandom & $urandom), $urandom_range(0, 3) != 0);
        end
        drain();

        // Reset in the middle of a burst from requester 7.
        reached = 1'b0;
        for (int n = 0; n < 20; n++) begin
            cycle(8'h80, 8'h00, 1'b1);
            if (m_busy && m_count == 2) begin
                reached = 1'b1;
                break;
            end
        end
        if (!reached) fail_now("midburst_setup");
        mon_en = 1'b0;
        #2;
        rst_ni = 1'b0;
        #1;
        check("midrst_grant", 64'(grant_o), 64'h0);
        check("midrst_busy", 64'(busy_o), 64'h0);
        check("midrst_valid", 64'(valid_o), 64'h0);
        check("midrst_select", 64'(select_o), 64'h0);
        model_reset();
        @(posedge clk_i);
        #1;
        rst_ni = 1'b1;
        mon_en = 1'b1;
        cycle(8'h81, 8'h00, 1'b1);
        check("post_reset_winner", 64'(grant_o), 64'h01);
        cycle(8'h81, 8'h01, 1'b1);
        drain();
        mon_en = 1'b0;

        check("beat_queue_empty", 64'(beat_q.size()), 64'h0);
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
